// File: rtl/viterbi_ber_checker_if.sv
// Reference-bit and decoded-bit strobes feeding the BER checker.
// The encoder/decoder side drives through master; the checker listens through slave.
interface viterbi_ber_checker_if;
  logic ref_valid_i;
  logic ref_bit_i;
  logic dec_valid_i;
  logic dec_bit_i;

  modport master (output ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i);
  modport slave  (input  ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i);
endinterface

// File: rtl/viterbi_ber_checker.sv
// Pairs decoded bits with buffered reference bits and counts bit errors.
// Lock status is taken from the error density of each WIN-bit window.
module viterbi_ber_checker #(
  parameter int DEPTH    = 64,
  parameter int SKIP     = 0,
  parameter int CNT_W    = 32,
  parameter int WIN      = 256,
  parameter int LOSS_THR = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  viterbi_ber_checker_if.slave   s_if,
  input  logic                   clear_i,
  output logic [CNT_W-1:0]       bit_count_o,
  output logic [CNT_W-1:0]       err_count_o,
  output logic                   err_o,
  output logic                   locked_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int WW    = $clog2(WIN + 1);
  localparam int WW1   = WW + 1;
  localparam int SKW   = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int THR_C = (LOSS_THR > WIN) ? WIN + 1 : LOSS_THR;

  localparam logic [LW-1:0]  FULL_LVL  = LW'(DEPTH);
  localparam logic [WW-1:0]  WIN_LAST  = WW'(WIN - 1);
  localparam logic [WW:0]    THR       = WW1'(THR_C);
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam bit             NO_SKIP   = (SKIP == 0);

  typedef enum logic {SKIPPING, TRACKING} state_t;

  state_t           r_state, w_state_nxt;
  logic [SKW-1:0]   r_skip_cnt, w_skip_nxt;
  logic             r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_vld_p1, r_mis_p1;
  logic [CNT_W-1:0] r_bit_count, r_err_count;
  logic             r_err, r_locked, r_overflow, r_underflow;
  logic [WW-1:0]    r_win_bits, r_win_errs;

  logic w_full, w_empty, w_push, w_pop, w_cmp;
  logic [WW-1:0] w_win_errs_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_full       = (r_level == FULL_LVL);
  assign w_empty      = (r_level == '0);
  assign w_pop        = s_if.dec_valid_i & ~w_empty;
  // A full FIFO still accepts a push when the same cycle pops.
  assign w_push       = s_if.ref_valid_i & (~w_full | s_if.dec_valid_i);
  assign w_cmp        = w_pop & ((r_state == TRACKING) | NO_SKIP);
  assign w_win_errs_n = r_win_errs + WW'(r_mis_p1);

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    if (clear_i) begin
      w_state_nxt = SKIPPING;
      w_skip_nxt  = '0;
    end else if (r_state == SKIPPING) begin
      if (NO_SKIP) begin
        w_state_nxt = TRACKING;
      end else if (w_pop) begin
        if (r_skip_cnt == SKIP_LAST) begin
          w_state_nxt = TRACKING;
          w_skip_nxt  = '0;
        end else begin
          w_skip_nxt = r_skip_cnt + SKW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SKIPPING;
      r_skip_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;
    end
  end

  // Stage p0 -> p1: FIFO read and compare; data path carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_if.ref_bit_i;
    r_mis_p1 <= s_if.dec_bit_i ^ r_mem[r_rptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_vld_p1    <= 1'b0;
      r_bit_count <= '0;
      r_err_count <= '0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
    end else if (clear_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_vld_p1    <= 1'b0;
      r_bit_count <= '0;
      r_err_count <= '0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (s_if.ref_valid_i & w_full & ~s_if.dec_valid_i) r_overflow <= 1'b1;
      if (s_if.dec_valid_i & w_empty) r_underflow <= 1'b1;
      r_vld_p1 <= w_cmp;
      r_err    <= 1'b0;
      // Stage p1 -> outputs: counters, error pulse, window lock decision.
      if (r_vld_p1) begin
        r_bit_count <= sat_inc(r_bit_count);
        if (r_mis_p1) begin
          r_err_count <= sat_inc(r_err_count);
          r_err       <= 1'b1;
        end
        if (r_win_bits == WIN_LAST) begin
          r_locked   <= ({1'b0, w_win_errs_n} < THR);
          r_win_bits <= '0;
          r_win_errs <= '0;
        end else begin
          r_win_bits <= r_win_bits + WW'(1);
          r_win_errs <= w_win_errs_n;
        end
      end
    end
  end

  assign bit_count_o = r_bit_count;
  assign err_count_o = r_err_count;
  assign err_o       = r_err;
  assign locked_o    = r_locked;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;
  assign level_o     = r_level;
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: default, SKIP=8 and DEPTH=4 instances share one clock.
// Table vectors exercise the small FIFO; hand sequences cover streams, latency, clear, reset.
module tb_viterbi_ber_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  viterbi_ber_checker_if if0 ();
  viterbi_ber_checker_if if1 ();
  viterbi_ber_checker_if if2 ();

  logic        clr0, clr1, clr2;
  logic [31:0] bc0, ec0, bc1, ec1, bc2, ec2;
  logic        err0, lk0, ovf0, udf0, err1, lk1, ovf1, udf1, err2, lk2, ovf2, udf2;
  logic [6:0]  lvl0, lvl1;
  logic [2:0]  lvl2;

  viterbi_ber_checker u_dut0 (
    .clk(clk), .rst(rst), .s_if(if0), .clear_i(clr0),
    .bit_count_o(bc0), .err_count_o(ec0), .err_o(err0), .locked_o(lk0),
    .overflow_o(ovf0), .underflow_o(udf0), .level_o(lvl0));

  viterbi_ber_checker #(.SKIP(8)) u_dut1 (
    .clk(clk), .rst(rst), .s_if(if1), .clear_i(clr1),
    .bit_count_o(bc1), .err_count_o(ec1), .err_o(err1), .locked_o(lk1),
    .overflow_o(ovf1), .underflow_o(udf1), .level_o(lvl1));

  viterbi_ber_checker #(.DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .s_if(if2), .clear_i(clr2),
    .bit_count_o(bc2), .err_count_o(ec2), .err_o(err2), .locked_o(lk2),
    .overflow_o(ovf2), .underflow_o(udf2), .level_o(lvl2));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int rv, rb, dv, db, clr;
    int lvl, ovf, udf, bc, ec, err;
  } vec_t;
  vec_t tbl[18];

  // Error-pulse / lock monitor on the default instance
  int err_pulses = 0;
  int err_bc[4];
  int lock_at = -1;
  logic prev_lk = 1'b0;
  always @(negedge clk) begin
    if (err0) begin
      if (err_pulses < 4) err_bc[err_pulses] = int'(bc0);
      err_pulses++;
    end
    if (lk0 && !prev_lk && lock_at < 0) lock_at = int'(bc0);
    prev_lk = lk0;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic refbit(input int i);
    logic [31:0] h;
    h = 32'(i) * 32'h9E3779B1;
    return h[17] ^ h[29];
  endfunction

  function automatic logic inv_bit(input int j, input int mode);
    if (mode == 1) return (j == 5) || (j == 100);
    if (mode == 2) return (j < 256) && (j % 4 == 3);
    return 1'b0;
  endfunction

  task automatic idle_all();
    if0.ref_valid_i = 0; if0.ref_bit_i = 0; if0.dec_valid_i = 0; if0.dec_bit_i = 0;
    if1.ref_valid_i = 0; if1.ref_bit_i = 0; if1.dec_valid_i = 0; if1.dec_bit_i = 0;
    if2.ref_valid_i = 0; if2.ref_bit_i = 0; if2.dec_valid_i = 0; if2.dec_bit_i = 0;
    clr0 = 0; clr1 = 0; clr2 = 0;
  endtask

  task automatic clear_mon();
    err_pulses = 0;
    lock_at    = -1;
    for (int k = 0; k < 4; k++) err_bc[k] = -1;
  endtask

  task automatic do_clear0();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    @(negedge clk);
    clear_mon();
  endtask

  // Decoder echoes the reference stream 10 cycles later, with optional inversions
  task automatic run_echo(input int n, input int mode);
    for (int t = 0; t < n + 10; t++) begin
      if0.ref_valid_i = (t < n);
      if0.ref_bit_i   = refbit(t);
      if0.dec_valid_i = (t >= 10);
      if0.dec_bit_i   = (t >= 10) ? (refbit(t - 10) ^ inv_bit(t - 10, mode)) : 1'b0;
      @(negedge clk);
    end
    idle_all();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    //           rv rb dv db clr  lvl ovf udf bc ec err
    tbl[0]  = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0,   3, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0,   4, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 1, 0,   4, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0,   4, 1, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 0,   3, 1, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0,   3, 1, 0, 2, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 0,   3, 1, 0, 2, 1, 0};
    tbl[9]  = '{1, 0, 1, 1, 0,   3, 1, 0, 2, 1, 0};
    tbl[10] = '{0, 0, 1, 0, 0,   2, 1, 0, 3, 1, 0};
    tbl[11] = '{0, 0, 1, 0, 0,   1, 1, 0, 4, 2, 1};
    tbl[12] = '{0, 0, 1, 1, 0,   0, 1, 0, 5, 2, 0};
    tbl[13] = '{1, 1, 1, 0, 0,   1, 1, 1, 6, 3, 1};
    tbl[14] = '{0, 0, 0, 0, 0,   1, 1, 1, 6, 3, 0};
    tbl[15] = '{1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0};

    idle_all();
    clear_mon();
    repeat (2) @(negedge clk);
    chk("rst.bit_count", bc0, 0);
    chk("rst.err_count", ec0, 0);
    chk("rst.err", err0, 0);
    chk("rst.locked", lk0, 0);
    chk("rst.overflow", ovf0, 0);
    chk("rst.underflow", udf0, 0);
    chk("rst.level", lvl0, 0);
    rst = 1'b1;
    @(negedge clk);

    // DEPTH=4 instance: overflow, full push+pop, underflow, clear
    for (int i = 0; i < 18; i++) begin
      if2.ref_valid_i = (tbl[i].rv != 0);
      if2.ref_bit_i   = (tbl[i].rb != 0);
      if2.dec_valid_i = (tbl[i].dv != 0);
      if2.dec_bit_i   = (tbl[i].db != 0);
      clr2            = (tbl[i].clr != 0);
      @(negedge clk);
      chk($sformatf("v%0d.level", i), lvl2, tbl[i].lvl);
      chk($sformatf("v%0d.overflow", i), ovf2, tbl[i].ovf);
      chk($sformatf("v%0d.underflow", i), udf2, tbl[i].udf);
      chk($sformatf("v%0d.bit_count", i), bc2, tbl[i].bc);
      chk($sformatf("v%0d.err_count", i), ec2, tbl[i].ec);
      chk($sformatf("v%0d.err", i), err2, tbl[i].err);
      chk($sformatf("v%0d.locked", i), lk2, 0);
    end
    idle_all();
    @(negedge clk);

    // Compare latency: mismatching pop, err_o one cycle later for one cycle
    if0.ref_valid_i = 1; if0.ref_bit_i = 1;
    @(negedge clk);
    chk("lat.level_push", lvl0, 1);
    if0.ref_valid_i = 0; if0.dec_valid_i = 1; if0.dec_bit_i = 0;
    @(negedge clk);
    idle_all();
    chk("lat.err_at_pop", err0, 0);
    chk("lat.bc_at_pop", bc0, 0);
    @(negedge clk);
    chk("lat.err_next", err0, 1);
    chk("lat.ec_next", ec0, 1);
    chk("lat.bc_next", bc0, 1);
    @(negedge clk);
    chk("lat.err_gone", err0, 0);

    // Clear beats a same-cycle push/pop
    if0.ref_valid_i = 1; if0.ref_bit_i = 1;
    repeat (3) @(negedge clk);
    chk("clr.level_before", lvl0, 3);
    if0.dec_valid_i = 1; clr0 = 1;
    @(negedge clk);
    idle_all();
    chk("clr.level", lvl0, 0);
    chk("clr.bit_count", bc0, 0);
    chk("clr.err_count", ec0, 0);
    chk("clr.err", err0, 0);
    @(negedge clk);
    chk("clr.bit_count_later", bc0, 0);

    // Test 1: clean stream of 300
    do_clear0();
    run_echo(300, 0);
    chk("t1.bit_count", bc0, 300);
    chk("t1.err_count", ec0, 0);
    chk("t1.locked", lk0, 1);
    chk("t1.lock_at", lock_at, 256);
    chk("t1.err_pulses", err_pulses, 0);
    chk("t1.level", lvl0, 0);

    // Test 2: bits 5 and 100 inverted
    do_clear0();
    run_echo(300, 1);
    chk("t2.bit_count", bc0, 300);
    chk("t2.err_count", ec0, 2);
    chk("t2.err_pulses", err_pulses, 2);
    chk("t2.err_bc0", err_bc[0], 6);
    chk("t2.err_bc1", err_bc[1], 101);
    chk("t2.locked", lk0, 1);

    // Test 3: 64 errors in first window, clean second window
    do_clear0();
    run_echo(512, 2);
    chk("t3.err_count", ec0, 64);
    chk("t3.bit_count", bc0, 512);
    chk("t3.lock_at", lock_at, 512);
    chk("t3.locked", lk0, 1);

    // Asynchronous reset mid-stream
    if0.ref_valid_i = 1; if0.ref_bit_i = 1;
    repeat (5) @(negedge clk);
    chk("rs.level_before", lvl0, 5);
    #2 rst = 1'b0;
    #1;
    chk("rs.bit_count", bc0, 0);
    chk("rs.err_count", ec0, 0);
    chk("rs.locked", lk0, 0);
    chk("rs.level", lvl0, 0);
    chk("rs.err", err0, 0);
    chk("rs.overflow", ovf0, 0);
    chk("rs.underflow", udf0, 0);
    chk("rs.level_small", lvl2, 0);
    idle_all();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_mon();
    run_echo(30, 0);
    chk("rs.restart_bc", bc0, 30);
    chk("rs.restart_ec", ec0, 0);
    chk("rs.restart_locked", lk0, 0);
    chk("rs.restart_pulses", err_pulses, 0);

    // Test 4: SKIP=8, first 8 decoded bits are garbage
    for (int t = 0; t < 22; t++) begin
      if1.ref_valid_i = (t < 20);
      if1.ref_bit_i   = refbit(t + 7);
      if1.dec_valid_i = (t >= 2);
      if1.dec_bit_i   = (t >= 2) ? (refbit(t + 5) ^ (t < 10)) : 1'b0;
      @(negedge clk);
    end
    idle_all();
    repeat (3) @(negedge clk);
    chk("t4.bit_count", bc1, 12);
    chk("t4.err_count", ec1, 0);
    chk("t4.level", lvl1, 0);
    chk("t4.underflow", udf1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
